// File: rtl/neuron_core_wb_master.sv
// neuron_core_wb_master: Wishbone classic initiator for the neuron_core slave.
// Commands arrive on a valid/ready stream and are queued in a small FIFO.
// Each command becomes one single Wishbone transfer and returns one response.
// A transfer with no ack for TIMEOUT_CYCLES cycles is aborted with rsp_err_o=1.
// Optional build macro NEURON_WB_MASTER_STATS_EN adds transaction/error counters.
module neuron_core_wb_master #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
`ifdef NEURON_WB_MASTER_STATS_EN
  ,
  output logic [15:0] txn_count_o,
  output logic [7:0]  err_count_o
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state;
  cmd_t        mem [FIFO_DEPTH];
  cmd_t        cmd_in;
  cmd_t        head;
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop;
  logic [15:0] tmo_cnt;

  // Pointers carry one wrap bit above the index so full and empty differ.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  // Gated by rst_n so every output reads 0 while reset is held.
  assign cmd_ready_o = ~full & rst_n;
  assign push   = cmd_valid_i & cmd_ready_o;
  assign pop    = (state == IDLE) & ~empty;
  assign cmd_in = '{we: cmd_we_i, adr: cmd_adr_i, dat: cmd_dat_i, sel: cmd_sel_i};
  assign head   = mem[rd_ptr[AW-1:0]];
  assign busy_o = ~empty | (state != IDLE);

  // FIFO storage; contents need no reset since the pointers qualify them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= cmd_in;
  end

  // FIFO pointers; push and pop in the same cycle both advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Transfer FSM: launch head, wait for ack or timeout, hold response until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      tmo_cnt     <= '0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= head.we;
            wbm_adr_o <= head.adr;
            wbm_dat_o <= head.dat;
            wbm_sel_o <= head.sel;
            tmo_cnt   <= '0;
            state     <= REQ;
          end
        end
        REQ: begin
          // Ack takes priority over a timeout landing on the same edge.
          if (wbm_ack_i) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            rsp_dat_o   <= wbm_we_o ? 32'd0 : wbm_dat_i;
            rsp_err_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b1;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NEURON_WB_MASTER_STATS_EN
  // Response counters: total wraps, errors saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_count_o <= '0;
      err_count_o <= '0;
    end else if (rsp_valid_o && rsp_ready_i) begin
      txn_count_o <= txn_count_o + 16'd1;
      if (rsp_err_o && (err_count_o != 8'hFF)) err_count_o <= err_count_o + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_neuron_core_wb_master.sv
// Bench for neuron_core_wb_master: directed cases plus randomized traffic.
// A bench-side Wishbone slave acks after a per-command delay; expected responses
// come from that delay and an address-derived read value.
module tb_neuron_core_wb_master;
  localparam int TO = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid_i = 1'b0, cmd_ready_o, cmd_we_i = 1'b0;
  logic [31:0] cmd_adr_i = '0, cmd_dat_i = '0;
  logic [3:0]  cmd_sel_i = '0;
  logic        rsp_valid_o, rsp_ready_i = 1'b0, rsp_err_o, busy_o;
  logic [31:0] rsp_dat_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
`ifdef NEURON_WB_MASTER_STATS_EN
  logic [15:0] txn_count_o;
  logic [7:0]  err_count_o;
`endif

  always #5 clk = ~clk;

  neuron_core_wb_master #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
    .rsp_err_o(rsp_err_o), .busy_o(busy_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
`ifdef NEURON_WB_MASTER_STATS_EN
    , .txn_count_o(txn_count_o), .err_count_o(err_count_o)
`endif
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          d;
  } tcmd_t;
  typedef struct {
    logic [31:0] dat;
    logic        err;
  } trsp_t;

  tcmd_t exp_cmd[$];
  trsp_t exp_rsp[$];
  int    n_tests = 0, n_fail = 0;
  int    n_hs = 0, n_err = 0;
  int    rdy_mode = 0;   // 0 random, 1 hold low, 2 hold high
  bit    quiet = 1'b1;   // suppress monitors around reset

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return a ^ 32'hB000_8003;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Queue one command; expectations are recorded when the handshake happens.
  task automatic push(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input int d);
    bit acc = 1'b0;
    int n = 0;
    tcmd_t c;
    trsp_t r;
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel;
    while (!acc && n < 300) begin
      @(negedge clk); acc = cmd_ready_o;
      @(posedge clk); #1; n++;
    end
    cmd_valid_i = 1'b0;
    if (!acc) check("cmd_accept_bound", 0, 1);
    else begin
      c = '{we: we, adr: adr, dat: dat, sel: sel, d: d};
      r.err = (d >= TO);
      r.dat = (we || r.err) ? 32'd0 : slv_rd(adr);
      exp_cmd.push_back(c);
      exp_rsp.push_back(r);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((exp_rsp.size() != 0 || busy_o) && n < max) begin tick(1); n++; end
    check("drain_bound", (exp_rsp.size() == 0 && !busy_o), 1);
  endtask

  // Response ready driver.
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      1:       rsp_ready_i = 1'b0;
      2:       rsp_ready_i = 1'b1;
      default: rsp_ready_i = ($urandom % 3) != 0;
    endcase
  end

  // Wishbone slave: acks after cur.d wait cycles, checks launch fields and stb length.
  initial begin
    bit    trk = 1'b0;
    tcmd_t cur;
    int    w = 0, dur = 0, exp_dur;
    wbm_ack_i = 1'b0; wbm_dat_i = '0;
    cur = '{we: 1'b0, adr: '0, dat: '0, sel: '0, d: 0};
    forever begin
      @(posedge clk); #1;
      if (quiet || !rst_n) begin
        trk = 1'b0; wbm_ack_i = 1'b0;
      end else if (wbm_cyc_o) begin
        if (!trk) begin
          trk = 1'b1; w = 0; dur = 0;
          if (exp_cmd.size() == 0) begin
            check("cyc_unexpected", 1, 0);
            cur = '{we: 1'b0, adr: '0, dat: '0, sel: '0, d: 0};
          end else begin
            cur = exp_cmd.pop_front();
            check("launch_adr", wbm_adr_o, cur.adr);
            check("launch_we", wbm_we_o, cur.we);
            check("launch_sel", wbm_sel_o, cur.sel);
            if (cur.we) check("launch_dat", wbm_dat_o, cur.dat);
          end
        end else begin
          check("hold_adr", wbm_adr_o, cur.adr);
          check("hold_we", wbm_we_o, cur.we);
        end
        check("stb_eq_cyc", wbm_stb_o, 1);
        dur++;
        if (w == cur.d) begin
          wbm_ack_i = 1'b1;
          wbm_dat_i = cur.we ? $urandom : slv_rd(wbm_adr_o);
        end else begin
          wbm_ack_i = 1'b0;
          wbm_dat_i = $urandom;
          w++;
        end
      end else begin
        if (trk) begin
          exp_dur = (cur.d + 1 < TO) ? cur.d + 1 : TO;
          check("stb_cycles", dur, exp_dur);
          trk = 1'b0;
        end
        // Stray acks while cyc is low must be ignored.
        wbm_ack_i = ($urandom % 5) == 0;
        wbm_dat_i = $urandom;
      end
    end
  end

  // Response monitor / scoreboard.
  initial begin
    bit          pend = 1'b0;
    logic [31:0] pd;
    logic        pe;
    trsp_t       e;
    forever begin
      @(negedge clk);
      if (quiet || !rst_n) pend = 1'b0;
      else begin
        check("busy", busy_o, exp_rsp.size() != 0);
        if (pend) begin
          check("rsp_hold_valid", rsp_valid_o, 1);
          check("rsp_hold_dat", rsp_dat_o, pd);
          check("rsp_hold_err", rsp_err_o, pe);
        end
        if (rsp_valid_o) check("no_cyc_in_rsp", wbm_cyc_o, 0);
        if (rsp_valid_o && rsp_ready_i) begin
          if (exp_rsp.size() == 0) check("rsp_unexpected", 1, 0);
          else begin
            e = exp_rsp.pop_front();
            check("rsp_dat", rsp_dat_o, e.dat);
            check("rsp_err", rsp_err_o, e.err);
            n_hs++;
            if (e.err) n_err++;
          end
          pend = 1'b0;
        end else if (rsp_valid_o) begin
          pend = 1'b1; pd = rsp_dat_o; pe = rsp_err_o;
        end else pend = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d, r;
    // Reset state.
    #12;
    check("rst_cmd_ready", cmd_ready_o, 0);
    check("rst_cyc", wbm_cyc_o, 0);
    check("rst_stb", wbm_stb_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_busy", busy_o, 0);
    @(negedge clk); rst_n = 1'b1;
    tick(1);
    quiet = 1'b0;
    check("post_rst_ready", cmd_ready_o, 1);
    check("post_rst_busy", busy_o, 0);

    // Write acked on the first stb cycle, then a read after 3 wait cycles.
    rdy_mode = 2;
    push(1'b1, 32'h3000_4000, 32'hA5A5_0001, 4'hF, 0);
    wait_idle(50);
    push(1'b0, 32'h3000_8000, 32'h0, 4'hF, 3);
    wait_idle(50);

    // Timeout followed by a normal command, then ack exactly on the timeout edge.
    push(1'b0, 32'h3000_0010, 32'h0, 4'hF, 50);
    push(1'b1, 32'h3000_0014, 32'h1234_5678, 4'h3, 1);
    push(1'b0, 32'h3000_0018, 32'h0, 4'hF, TO - 1);
    wait_idle(100);

    // Fill the FIFO behind a response stuck in RESP.
    rdy_mode = 1;
    push(1'b0, 32'h3000_1000, 32'h0, 4'hF, 1);
    n = 0;
    while (!rsp_valid_o && n < 50) begin tick(1); n++; end
    check("stuck_rsp_valid", rsp_valid_o, 1);
    for (int i = 0; i < DEPTH; i++) push(1'b1, 32'h3000_2000 + 32'(4 * i), $urandom, 4'hF, i);
    check("ready_low_full", cmd_ready_o, 0);
    fork
      push(1'b0, 32'h3000_2100, 32'h0, 4'hF, 2);
      begin
        tick(5);
        check("fifth_waiting", exp_rsp.size(), DEPTH + 1);
        rdy_mode = 2;
      end
    join
    wait_idle(200);

    // Randomized traffic.
    rdy_mode = 0;
    for (int i = 0; i < 40; i++) begin
      r = $urandom % 10;
      if (r < 6)       d = r % 4;
      else if (r == 6) d = TO - 1;
      else if (r == 7) d = TO;
      else if (r == 8) d = TO + 1 + ($urandom % 4);
      else             d = $urandom % 6;
      push($urandom % 2, $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom), d);
      tick($urandom % 3);
    end
    wait_idle(2000);

`ifdef NEURON_WB_MASTER_STATS_EN
    check("txn_count", txn_count_o, 16'(n_hs));
    check("err_count", err_count_o, (n_err > 255) ? 255 : n_err);
`endif

    // Held response, then reset during the next command's REQ.
    rdy_mode = 1;
    push(1'b0, 32'h3000_3000, 32'h0, 4'hF, 2);
    push(1'b0, 32'h3000_3004, 32'h0, 4'hF, 1000);
    n = 0;
    while (!rsp_valid_o && n < 50) begin tick(1); n++; end
    check("held_rsp_valid", rsp_valid_o, 1);
    tick(10);
    check("held_no_cyc", wbm_cyc_o, 0);
    rdy_mode = 2;
    n = 0;
    while (!wbm_cyc_o && n < 20) begin tick(1); n++; end
    check("next_cyc_launched", wbm_cyc_o, 1);
    tick(3);
    #2;
    quiet = 1'b1;
    rst_n = 1'b0;
    #1;
    check("async_cyc_drop", wbm_cyc_o, 0);
    check("async_stb_drop", wbm_stb_o, 0);
    check("rst_rsp_drop", rsp_valid_o, 0);
    exp_cmd.delete();
    exp_rsp.delete();
`ifdef NEURON_WB_MASTER_STATS_EN
    check("rst_txn_count", txn_count_o, 0);
    check("rst_err_count", err_count_o, 0);
`endif
    tick(2);
    @(negedge clk); rst_n = 1'b1;
    tick(1);
    quiet = 1'b0;
    check("post_rst2_busy", busy_o, 0);
    check("post_rst2_ready", cmd_ready_o, 1);
    tick(5);
    check("post_rst2_no_cyc", wbm_cyc_o, 0);
    check("post_rst2_no_rsp", rsp_valid_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
